// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage: sized loads/stores with fixed wait states.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN (adds AlignErr port).
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        AlignErr
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam logic [1:0]  SzWord = 2'b01;
  localparam logic [1:0]  SzHalf = 2'b10;
  localparam logic [1:0]  SzByte = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
`ifdef MISALIGN_TRAP_EN
  logic              aerr_q, aerr_d;
`endif

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        req;
  logic        access;
  logic        misaligned;
  logic        mem_we;
  logic [31:0] cur_word;
  logic [31:0] load_val;
  logic [31:0] store_val;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        unused_addr_hi;

  // Address bits above the word index wrap the memory and carry no information.
  assign unused_addr_hi = ^Address[31:IdxW+2];

  assign req      = (MemRead != 2'b00) || (MemWrite != 2'b00);
  assign cur_word = mem_q[idx_q];
  assign access   = (state_q == StWait) && (cnt_q <= 4'd1);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size_q == SzWord) && (lane_q != 2'b00)) ||
                      ((size_q == SzHalf) && lane_q[0]);
`else
  assign misaligned = 1'b0;
`endif

  assign mem_we = access && is_wr_q && !misaligned;

  // Load path: pick the lane(s) and sign-extend.
  always_comb begin
    half_sel = lane_q[1] ? cur_word[31:16] : cur_word[15:0];
    byte_sel = cur_word[7:0];
    case (lane_q)
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      2'd3:    byte_sel = cur_word[31:24];
      default: byte_sel = cur_word[7:0];
    endcase
    case (size_q)
      SzHalf:  load_val = {{16{half_sel[15]}}, half_sel};
      SzByte:  load_val = {{24{byte_sel[7]}}, byte_sel};
      default: load_val = cur_word;
    endcase
  end

  // Store path: merge the selected lane(s) into the current word.
  always_comb begin
    store_val = cur_word;
    case (size_q)
      SzHalf: begin
        if (lane_q[1]) store_val[31:16] = wdata_q[15:0];
        else           store_val[15:0]  = wdata_q[15:0];
      end
      SzByte: begin
        case (lane_q)
          2'd1:    store_val[15:8]  = wdata_q[7:0];
          2'd2:    store_val[23:16] = wdata_q[7:0];
          2'd3:    store_val[31:24] = wdata_q[7:0];
          default: store_val[7:0]   = wdata_q[7:0];
        endcase
      end
      default: store_val = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    aerr_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = WaitInit;
          idx_d   = Address[IdxW+1:2];
          lane_d  = Address[1:0];
          wdata_d = WriteData;
          // A store wins when both request codes are present.
          is_wr_d = (MemWrite != 2'b00);
          size_d  = (MemWrite != 2'b00) ? MemWrite : MemRead;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (access) begin
          state_d = StDone;
          done_d  = 1'b1;
`ifdef MISALIGN_TRAP_EN
          aerr_d  = misaligned;
`endif
          if (!is_wr_q && !misaligned) rdata_d = load_val;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      aerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
`ifdef MISALIGN_TRAP_EN
      aerr_q  <= aerr_d;
`endif
    end
  end

  // Storage is never cleared; a reset forces StIdle so a pending store is dropped.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[idx_q] <= store_val;
  end

  assign Busy     = !Reset && (((state_q == StIdle) && req) || (state_q == StWait));
  assign ReadData = rdata_q;
  assign Done     = done_q;
`ifdef MISALIGN_TRAP_EN
  assign AlignErr = aerr_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: transaction-level memory model, per-cycle compare.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned W     = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address, WriteData;
  logic [1:0]  MemRead, MemWrite;
  logic [31:0] ReadData;
  logic        Busy, Done;
  logic        AlignErr;

  data_mem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .Busy     (Busy),
    .Done     (Done)
`ifdef MISALIGN_TRAP_EN
    ,
    .AlignErr (AlignErr)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign AlignErr = 1'b0;
`endif

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_m [Depth];
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_ae   = 1'b0;
  logic [31:0] exp_rd   = 32'd0;
  int          busy_run = 0;
  int          last_busy = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mis(input logic [1:0] sz, input logic [1:0] lo);
`ifdef MISALIGN_TRAP_EN
    return ((sz == 2'd1) && (lo != 2'd0)) || ((sz == 2'd2) && lo[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lo);
    logic [31:0] v;
    if (sz == 2'd2) begin
      v = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
      if (v >= 32'h8000) v = v - 32'h10000;
    end else if (sz == 2'd3) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (v >= 32'h80) v = v - 32'h100;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] d);
    int sh;
    logic [31:0] mask;
    if (sz == 2'd1) return d;
    sh   = (sz == 2'd2) ? (lo[1] ? 16 : 0) : 8 * lo;
    mask = ((sz == 2'd2) ? 32'hFFFF : 32'hFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Per-cycle check of every output against the model's expectations.
  always @(negedge Clk) begin
    cmp("Busy", 32'(Busy), 32'(exp_busy));
    cmp("Done", 32'(Done), 32'(exp_done));
    cmp("ReadData", ReadData, exp_rd);
`ifdef MISALIGN_TRAP_EN
    cmp("AlignErr", 32'(AlignErr), 32'(exp_ae));
`endif
  end

  always @(negedge Clk) begin
    if (Reset) busy_run <= 0;
    else if (Done) begin
      last_busy <= busy_run;
      busy_run  <= 0;
    end else if (Busy) busy_run <= busy_run + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MemRead = 2'b00; MemWrite = 2'b00;
      exp_busy = 1'b0; exp_done = 1'b0; exp_ae = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic txn(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                     input logic [31:0] data);
    int unsigned idx;
    logic [1:0]  sz;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = data;
    exp_busy = (rd != 2'd0) || (wr != 2'd0);
    exp_done = 1'b0; exp_ae = 1'b0;
    @(posedge Clk); #1;
    if ((rd == 2'd0) && (wr == 2'd0)) return;
    for (int i = 0; i < int'(W); i++) begin
      MemRead = 2'($urandom); MemWrite = 2'($urandom);
      Address = $urandom; WriteData = $urandom;
      exp_busy = 1'b1;
      @(posedge Clk); #1;
    end
    idx = (addr >> 2) % Depth;
    sz  = (wr != 2'd0) ? wr : rd;
    if (wr != 2'd0) begin
      if (!mis(sz, addr[1:0])) mem_m[idx] = model_store(mem_m[idx], sz, addr[1:0], data);
    end else if (!mis(sz, addr[1:0])) begin
      exp_rd = model_load(mem_m[idx], sz, addr[1:0]);
    end
    // Requests seen during the completion cycle must be ignored.
    MemRead = 2'($urandom); MemWrite = 2'($urandom); Address = $urandom;
    exp_busy = 1'b0; exp_done = 1'b1; exp_ae = mis(sz, addr[1:0]);
    @(posedge Clk); #1;
    MemRead = 2'b00; MemWrite = 2'b00;
    exp_busy = 1'b0; exp_done = 1'b0; exp_ae = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Address = 32'd0; WriteData = 32'd0; MemRead = 2'b00; MemWrite = 2'b00;
    #2;
    cmp("rst_busy", 32'(Busy), 32'd0);
    cmp("rst_rdata", ReadData, 32'd0);
    cmp("rst_done", 32'(Done), 32'd0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    idle(2);

    txn(2'b00, 2'b01, 32'h10, 32'hDEADBEEF);
    cmp("sw_busy_cycles", 32'(last_busy), 32'd3);
    txn(2'b01, 2'b00, 32'h10, 32'h0);
    cmp("lw_10", ReadData, 32'hDEADBEEF);
    cmp("lw_busy_cycles", 32'(last_busy), 32'd3);

    txn(2'b00, 2'b11, 32'h13, 32'h80);
    txn(2'b11, 2'b00, 32'h13, 32'h0);
    cmp("lb_13", ReadData, 32'hFFFFFF80);
    txn(2'b01, 2'b00, 32'h10, 32'h0);
    cmp("lw_10_after_sb", ReadData, 32'h80ADBEEF);

    txn(2'b00, 2'b01, 32'h10, 32'h7FFF1234);
    txn(2'b10, 2'b00, 32'h12, 32'h0);
    cmp("lh_12", ReadData, 32'h00007FFF);
    txn(2'b10, 2'b00, 32'h10, 32'h0);
    cmp("lh_10", ReadData, 32'h00001234);

    txn(2'b01, 2'b01, 32'h20, 32'h5);
    cmp("rw_keeps_rdata", ReadData, 32'h00001234);
    txn(2'b01, 2'b00, 32'h20, 32'h0);
    cmp("lw_20", ReadData, 32'h5);

    // Abort a store mid-wait with reset.
    txn(2'b00, 2'b01, 32'h30, 32'h0);
    MemWrite = 2'b01; Address = 32'h30; WriteData = 32'hAAAA5555;
    exp_busy = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_rd = 32'd0;
    #1;
    cmp("abort_busy", 32'(Busy), 32'd0);
    cmp("abort_rdata", ReadData, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(1);
    txn(2'b01, 2'b00, 32'h30, 32'h0);
    cmp("lw_30_after_abort", ReadData, 32'h0);

    txn(2'b01, 2'b00, 32'h11, 32'h0);
`ifdef MISALIGN_TRAP_EN
    cmp("lw_11_trap", ReadData, 32'h0);
`else
    cmp("lw_11_aligned", ReadData, 32'h7FFF1234);
`endif

    // Randomized phase over 16 words, with random high bits exercising wrap-around.
    for (int i = 0; i < 16; i++) txn(2'b00, 2'b01, 32'(i * 4), $urandom);
    for (int n = 0; n < 200; n++) begin
      int unsigned k;
      logic [1:0]  rd, wr;
      logic [31:0] a;
      k  = $urandom_range(0, 9);
      rd = 2'b00; wr = 2'b00;
      if (k == 0) begin
        rd = 2'b00; wr = 2'b00;
      end else if (k == 1) begin
        rd = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(1, 3));
      end else if (k < 6) begin
        rd = 2'($urandom_range(1, 3));
      end else begin
        wr = 2'($urandom_range(1, 3));
      end
      a = ($urandom << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      txn(rd, wr, a, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
